// File: rtl/disp_scan_driver_if.sv
// Bundle between the scan driver and its host/segment-mux side.
// The host drives load/value/en; the driver returns the per-slot digit code and status.
interface disp_scan_driver_if;
   logic        load;
   logic [15:0] value;
   logic        en;
   logic [4:0]  data;
   logic [1:0]  sel;
   logic        frame_tick;
   logic        pending;

   modport master (
      output load, value, en,
      input  data, sel, frame_tick, pending
   );

   modport slave (
      input  load, value, en,
      output data, sel, frame_tick, pending
   );
endinterface

// File: rtl/disp_scan_driver.sv
// Four-digit seven-segment scan driver with frame-synchronous double buffering.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits 1..3.
module disp_scan_driver #(
   parameter int CLK_DIV = 50000
) (
   input  logic               clk,
   input  logic               rst_n,
   disp_scan_driver_if.slave  bus
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       sel_q;
   logic [15:0]      shadow;
   logic [15:0]      active;
   logic             pending_q;
   logic [4:0]       data_q;
   logic             tick_q;

   logic             adv;
   logic             fb;
   logic [1:0]       sel_nxt;
   logic [15:0]      active_nxt;
   logic             pending_nxt;
   logic [4:0]       data_nxt;
   logic [3:0]       digit;
   logic             blank;

   assign adv     = (div_cnt == DIV_LAST);
   assign fb      = adv && (sel_q == 2'd3);
   assign sel_nxt = adv ? sel_q + 2'd1 : sel_q;

   // A load coinciding with the boundary commits the older shadow and stays pending.
   assign active_nxt  = (fb && pending_q) ? shadow : active;
   assign pending_nxt = bus.load ? 1'b1 : (fb ? 1'b0 : pending_q);

   always_comb begin
      digit    = 4'h0;
      blank    = 1'b0;
      data_nxt = 5'h1F;
      case (sel_nxt)
         2'd0:    digit = active_nxt[3:0];
         2'd1:    digit = active_nxt[7:4];
         2'd2:    digit = active_nxt[11:8];
         default: digit = active_nxt[15:12];
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      case (sel_nxt)
         2'd1:    blank = (active_nxt[15:4] == 12'h000);
         2'd2:    blank = (active_nxt[15:8] == 8'h00);
         2'd3:    blank = (active_nxt[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
`else
      blank = 1'b0;
`endif
      if (bus.en && !blank) begin
         data_nxt = {1'b0, digit};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt   <= '0;
         sel_q     <= 2'd0;
         shadow    <= 16'h0000;
         active    <= 16'h0000;
         pending_q <= 1'b0;
         data_q    <= 5'h00;
         tick_q    <= 1'b0;
      end else begin
         div_cnt   <= adv ? '0 : div_cnt + DIV_W'(1);
         sel_q     <= sel_nxt;
         if (bus.load) begin
            shadow <= bus.value;
         end
         active    <= active_nxt;
         pending_q <= pending_nxt;
         data_q    <= data_nxt;
         tick_q    <= fb;
      end
   end

   assign bus.sel        = sel_q;
   assign bus.data       = data_q;
   assign bus.pending    = pending_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_disp_scan_driver.sv
// Scoreboard bench for disp_scan_driver: a cycle-count reference model predicts
// every post-edge output, and a negedge monitor compares them against the DUT.
module tb_disp_scan_driver;

   localparam int D     = 4;
   localparam int FRAME = 4 * D;

   typedef struct packed {
      logic [1:0] sel;
      logic [4:0] data;
      logic       pending;
      logic       tick;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   disp_scan_driver_if bus();

   disp_scan_driver #(.CLK_DIV(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t        exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          n           = 0;
   logic [15:0] m_shadow    = 16'h0000;
   logic [15:0] m_disp      = 16'h0000;
   logic        m_pend      = 1'b0;

   // Code shown for digit k of a displayed value under the current enable.
   function automatic logic [4:0] codeFor(input logic [15:0] v, input int k, input logic en_s);
      logic [15:0] s;
      s = v >> (4 * k);
      if (!en_s) return 5'h1F;
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && s == 16'h0000) return 5'h1F;
`endif
      return {1'b0, s[3:0]};
   endfunction

   task automatic checkOutput(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   // Reference model: edge n after reset release; slots are D edges, frames 4*D edges.
   always @(posedge clk or negedge rst_n) begin : model
      exp_t e;
      int   slot;
      if (!rst_n) begin
         n        = 0;
         m_shadow = 16'h0000;
         m_disp   = 16'h0000;
         m_pend   = 1'b0;
         exp_q.delete();
      end else begin
         n++;
         if ((n % FRAME) == 0 && m_pend) begin
            m_disp = m_shadow;
            m_pend = 1'b0;
         end
         if (bus.load) begin
            m_shadow = bus.value;
            m_pend   = 1'b1;
         end
         slot      = (n / D) % 4;
         e.sel     = 2'(slot);
         e.data    = codeFor(m_disp, slot, bus.en);
         e.pending = m_pend;
         e.tick    = ((n % FRAME) == 0);
         exp_q.push_back(e);
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("sel",        int'(bus.sel),        int'(e.sel));
         checkOutput("data",       int'(bus.data),       int'(e.data));
         checkOutput("pending",    int'(bus.pending),    int'(e.pending));
         checkOutput("frame_tick", int'(bus.frame_tick), int'(e.tick));
      end
   end

   // Drives one cycle of inputs starting at a falling edge.
   task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic e);
      bus.load  = ld;
      bus.value = v;
      bus.en    = e;
      @(negedge clk);
   endtask

   // Idles until the next rising edge is a frame boundary.
   task automatic alignToBoundary();
      int guard;
      guard = 0;
      while (((n + 1) % FRAME) != 0 && guard < 4 * FRAME) begin
         applyStimulus(1'b0, 16'h0000, 1'b1);
         guard++;
      end
      if (((n + 1) % FRAME) != 0) begin
         miscompares++;
         $display("[TB] FAIL align: boundary not reached within %0d cycles", 4 * FRAME);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stim
      bus.load  = 1'b0;
      bus.value = 16'h0000;
      bus.en    = 1'b1;

      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_sel",     int'(bus.sel),        0);
      checkOutput("reset_data",    int'(bus.data),       0);
      checkOutput("reset_pending", int'(bus.pending),    0);
      checkOutput("reset_tick",    int'(bus.frame_tick), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Free-running scan with no value loaded.
      repeat (2 * FRAME + 3) applyStimulus(1'b0, 16'h0000, 1'b1);

      // Mid-frame load becomes visible at the next boundary.
      applyStimulus(1'b1, 16'hBEEF, 1'b1);
      repeat (2 * FRAME) applyStimulus(1'b0, 16'h0000, 1'b1);

      // Load landing exactly on the boundary while an older value is pending.
      alignToBoundary();
      repeat (3) applyStimulus(1'b0, 16'h0000, 1'b1);
      applyStimulus(1'b1, 16'hAAAA, 1'b1);
      alignToBoundary();
      applyStimulus(1'b1, 16'h1234, 1'b1);
      repeat (2 * FRAME + 2) applyStimulus(1'b0, 16'h0000, 1'b1);

      // Enable dropped mid-slot, then restored.
      applyStimulus(1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0);
      repeat (D + 1) applyStimulus(1'b0, 16'h0000, 1'b1);

      // Leading-zero patterns (blanked only when the feature is built in).
      applyStimulus(1'b1, 16'h0070, 1'b1);
      repeat (2 * FRAME) applyStimulus(1'b0, 16'h0000, 1'b1);
      applyStimulus(1'b1, 16'h0000, 1'b1);
      repeat (2 * FRAME) applyStimulus(1'b0, 16'h0000, 1'b1);

      // Randomized loads and enable activity.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                       16'($urandom()),
                       ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
      end

      // Asynchronous reset in the middle of slot 2 with a value pending.
      alignToBoundary();
      applyStimulus(1'b1, 16'hC3C3, 1'b1);
      repeat (2 * D + 1) applyStimulus(1'b0, 16'h0000, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_sel",     int'(bus.sel),        0);
      checkOutput("async_rst_data",    int'(bus.data),       0);
      checkOutput("async_rst_pending", int'(bus.pending),    0);
      checkOutput("async_rst_tick",    int'(bus.frame_tick), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * FRAME + 2) applyStimulus(1'b0, 16'h0000, 1'b1);

      if (vectors < 1000) begin
         miscompares++;
         $display("[TB] FAIL coverage: only %0d vectors compared, expected at least 1000", vectors);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
